// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and the GF(2^8) xtime helper.
package aes_pkg;

  localparam logic [7:0] AES_POLY_LOW = 8'h1B;
  localparam int         STATE_W      = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_LOW : 8'h00);
  endfunction

endpackage

// File: rtl/gf_mix_col.sv
// One-column MixColumns / InvMixColumns; row 0 sits in the low byte.
module gf_mix_col
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] res
);

  logic [7:0] a  [4];
  logic [7:0] m2 [4];
  logic [7:0] m3 [4];
  logic [31:0] fres;

  for (genvar r = 0; r < 4; r++) begin : g_byte
    assign a[r]  = col[8*r +: 8];
    assign m2[r] = xtime(a[r]);
    assign m3[r] = m2[r] ^ a[r];
  end

  assign fres[7:0]   = m2[0] ^ m3[1] ^ a[2]  ^ a[3];
  assign fres[15:8]  = a[0]  ^ m2[1] ^ m3[2] ^ a[3];
  assign fres[23:16] = a[0]  ^ a[1]  ^ m2[2] ^ m3[3];
  assign fres[31:24] = m3[0] ^ a[1]  ^ a[2]  ^ m2[3];

  if (INV_EN) begin : g_inv
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] ires;

    for (genvar r = 0; r < 4; r++) begin : g_ibyte
      assign m4[r] = xtime(m2[r]);
      assign m8[r] = xtime(m4[r]);
      assign m9[r] = m8[r] ^ a[r];
      assign mb[r] = m8[r] ^ m2[r] ^ a[r];
      assign md[r] = m8[r] ^ m4[r] ^ a[r];
      assign me[r] = m8[r] ^ m4[r] ^ m2[r];
    end

    assign ires[7:0]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    assign ires[15:8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    assign ires[23:16] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    assign ires[31:24] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

    assign res = inv ? ires : fres;
  end else begin : g_fwd
    logic unused_inv;
    assign unused_inv = inv;
    assign res        = fres;
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Multi-cycle AES MixColumns engine, COLS_PER_CYCLE columns per clock,
// results written back in place into the working state register.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  localparam int N = COLS_PER_CYCLE;

  if (!(N == 1 || N == 2 || N == 4)) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e             state;
  logic [1:0]         cnt;
  logic [STATE_W-1:0] work;
  logic               mode;
  logic               last;

  logic [N-1:0][1:0]  idx;
  logic [N-1:0][31:0] col_in;
  logic [N-1:0][31:0] col_out;

  for (genvar g = 0; g < N; g++) begin : g_col
    assign idx[g] = cnt + 2'(g);
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign col_in[g][8*r +: 8] = work[8*(4*r + int'(idx[g])) +: 8];
    end
    gf_mix_col #(
      .INV_EN (INV_EN)
    ) u_col (
      .col (col_in[g]),
      .inv (mode),
      .res (col_out[g])
    );
  end

  // counter wraps to 0 after the final group, so N=4 is always last
  assign last = (cnt == 2'(4 - N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
      work  <= '0;
      mode  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            mode  <= INV_EN ? in_inv : 1'b0;
            cnt   <= 2'd0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int i = 0; i < N; i++) begin
            for (int r = 0; r < 4; r++) begin
              work[8*(4*r + int'(idx[i])) +: 8] <= col_out[i][8*r +: 8];
            end
          end
          cnt <= cnt + 2'(N);
          if (last) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_BUSY);
  assign out_data  = work;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench for mix_columns_engine: main instance plus two
// small instances covering wider column groups and forward-only builds.
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic         b_valid;
  logic [127:0] b_data;
  logic         b_inv;
  logic         b2_in_ready, b2_out_valid, b2_busy;
  logic [127:0] b2_out_data;
  logic         b4_in_ready, b4_out_valid, b4_busy;
  logic [127:0] b4_out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [127:0] expq[$];
  int           accq[$];
  logic         ov_q = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mix_columns_engine #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  mix_columns_engine #(.COLS_PER_CYCLE(2), .INV_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b2_in_ready),
    .in_data(b_data), .in_inv(b_inv), .out_valid(b2_out_valid),
    .out_ready(1'b1), .out_data(b2_out_data), .busy(b2_busy)
  );

  mix_columns_engine #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b4_in_ready),
    .in_data(b_data), .in_inv(b_inv), .out_valid(b4_out_valid),
    .out_ready(1'b1), .out_data(b4_out_data), .busy(b4_busy)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // columns given as {row0,row1,row2,row3}
  function automatic logic [127:0] pack(input logic [31:0] c0,
      input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0]  cs [4];
    logic [127:0] b;
    cs = '{c0, c1, c2, c3};
    b  = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[8*(4*r+c) +: 8] = cs[c][31-8*r -: 8];
    return b;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x,
                                      input logic [7:0] y);
    logic [7:0] p, a, b;
    logic       hi;
    p = 8'h00; a = x; b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] fwd_model(input logic [127:0] s);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] res;
    m   = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(m[(k - r + 4) % 4], s[8*(4*k+c) +: 8]);
        res[8*(4*r+c) +: 8] = acc;
      end
    return res;
  endfunction

  // monitor: latency on rising out_valid, data on each handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && !ov_q) begin
      if (accq.size() == 0) chk("latency_unexpected", 128'(1), 128'(0));
      else chk("latency", 128'(cyc - accq.pop_front()), 128'(4));
    end
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) chk("data_unexpected", out_data, '0);
      else chk("data", out_data, expq.pop_front());
    end
    ov_q <= rst_n && out_valid;
  end

  task automatic send(input logic [127:0] d, input logic inv,
                      input logic [127:0] exp);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 128'(0), 128'(1));
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    expq.push_back(exp);
    accq.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_inv   = ~inv;
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 128'(expq.size()), 128'(0));
  endtask

  task automatic collect(output int l2, output logic [127:0] d2,
                         output int l4, output logic [127:0] d4);
    int  t0;
    bit  s2, s4;
    s2 = 0; s4 = 0; l2 = -1; l4 = -1; d2 = '0; d4 = '0;
    t0 = cyc + 1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b2_out_valid && !s2) begin s2 = 1; l2 = cyc - t0; d2 = b2_out_data; end
      if (b4_out_valid && !s4) begin s4 = 1; l4 = cyc - t0; d4 = b4_out_data; end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] a_blk, fa_blk, r_blk, fr_blk, sd_blk, sf_blk;
    int           l2, l4;
    logic [127:0] d2, d4;

    a_blk  = pack(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    fa_blk = pack(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    sd_blk = pack(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
    sf_blk = pack(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0;
    out_ready = 1'b1; b_valid = 1'b0; b_data = '0; b_inv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    send(a_blk, 1'b0, fa_blk);
    send(sd_blk, 1'b0, sf_blk);
    send(fa_blk, 1'b1, a_blk);
    send(sf_blk, 1'b1, sd_blk);
    for (int n = 0; n < 3; n++) begin
      r_blk  = {$urandom, $urandom, $urandom, $urandom};
      fr_blk = fwd_model(r_blk);
      send(r_blk, 1'b0, fr_blk);
      send(fr_blk, 1'b1, r_blk);
    end
    drain();

    // stall in DONE with junk in_valid pulses
    out_ready = 1'b0;
    send(a_blk, 1'b0, fa_blk);
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk); #1;
    end
    chk("stall_reach_done", 128'(out_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      in_data  = ~a_blk;
      @(negedge clk);
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_out_data", out_data, fa_blk);
      chk("stall_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset in the middle of a block
    send(a_blk, 1'b0, fa_blk);
    @(posedge clk); #1;
    chk("mid_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    void'(expq.pop_back());
    void'(accq.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_data", out_data, '0);
    send(fa_blk, 1'b1, a_blk);
    drain();

    // wider column groups: COLS_PER_CYCLE 2 (forward only) and 4
    @(posedge clk); #1;
    b_valid = 1'b1; b_data = a_blk; b_inv = 1'b0;
    collect(l2, d2, l4, d4);
    chk("c2_latency", 128'(l2), 128'(2));
    chk("c2_data", d2, fa_blk);
    chk("c4_latency", 128'(l4), 128'(1));
    chk("c4_data", d4, fa_blk);

    @(posedge clk); #1;
    b_valid = 1'b1; b_data = a_blk; b_inv = 1'b1;
    collect(l2, d2, l4, d4);
    chk("fwd_only_ignores_inv", d2, fa_blk);
    chk("c2_latency_inv", 128'(l2), 128'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
